// File: rtl/decode_literal_merge_pkg.sv
// Shared decode-stage types and constants for the literal merge stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package decode_literal_merge_pkg;

    // Merge FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LIT = 2'd1,
        ST_HOLD     = 2'd2
    } lm_state_t;

    // Bit of the 33-bit literal word that flags a valid literal (fp_constant format)
    localparam int LIT_VALID_BIT = 32;

    // PC increments: base encoding size and trailing literal dword
    localparam int unsigned PC_INC_32  = 4;
    localparam int unsigned PC_INC_64  = 8;
    localparam int unsigned PC_INC_LIT = 4;

endpackage

// File: rtl/decode_literal_merge_if.sv
// Bundles the instruction, literal and issue channels of the literal merge stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; slave is the merge stage.
interface decode_literal_merge_if #(
    parameter int WFID_W = 6,
    parameter int PC_W   = 32
);
    // Decoded instruction channel
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_instr;
    logic              in_is64;
    logic [WFID_W-1:0] in_wfid;
    logic [PC_W-1:0]   in_pc;
    logic              in_lit_req;

    // Fetch literal stream
    logic              lit_valid;
    logic              lit_ready;
    logic [31:0]       lit_data;
    logic [WFID_W-1:0] lit_wfid;

    // Merged instruction to issue
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_instr;
    logic [WFID_W-1:0] out_wfid;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_next_pc;
    logic [32:0]       out_literal;
    logic              out_lit_err;

    modport master (
        output in_valid, in_instr, in_is64, in_wfid, in_pc, in_lit_req,
        output lit_valid, lit_data, lit_wfid,
        output out_ready,
        input  in_ready, lit_ready,
        input  out_valid, out_instr, out_wfid, out_pc, out_next_pc, out_literal, out_lit_err
    );

    modport slave (
        input  in_valid, in_instr, in_is64, in_wfid, in_pc, in_lit_req,
        input  lit_valid, lit_data, lit_wfid,
        input  out_ready,
        output in_ready, lit_ready,
        output out_valid, out_instr, out_wfid, out_pc, out_next_pc, out_literal, out_lit_err
    );
endinterface

// File: rtl/decode_literal_merge.sv
// Pairs a decoded instruction with its trailing literal dword and presents it to issue.
// Latency: 1 cycle after accept without literal; 1 cycle after literal consume otherwise.
// Backpressure: single-entry output register; in_ready follows out_ready in HOLD (zero bubble).
module decode_literal_merge
    import decode_literal_merge_pkg::*;
#(
    parameter int WFID_W = 6,
    parameter int PC_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [WFID_W-1:0]      flush_wfid,
    decode_literal_merge_if.slave  bus,
    output logic [15:0]            lit_count
);

    lm_state_t         state_q;
    logic              out_valid_q;
    logic [63:0]       instr_q;
    logic [WFID_W-1:0] wfid_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   next_pc_q;
    logic [32:0]       literal_q;
    logic              lit_err_q;
    logic [15:0]       lit_count_q;

    logic              flush_hit;
    logic              in_ready_d;
    logic              lit_ready_d;
    logic              accept;
    logic              lit_take;
    logic [PC_W-1:0]   next_pc_d;

    // Handshake decode: flush squashes both channels, reset holds everything off
    always_comb begin
        flush_hit   = flush && (flush_wfid == wfid_q) && (state_q != ST_IDLE);
        in_ready_d  = !rst && !flush &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));
        lit_ready_d = !rst && !flush_hit && (state_q == ST_WAIT_LIT);
        accept      = bus.in_valid && in_ready_d;
        lit_take    = bus.lit_valid && lit_ready_d;
        // Literal request is known at accept, so the full next PC is fixed then
        next_pc_d   = bus.in_pc
                    + (bus.in_is64    ? PC_W'(PC_INC_64)  : PC_W'(PC_INC_32))
                    + (bus.in_lit_req ? PC_W'(PC_INC_LIT) : PC_W'(0));
    end

    // Merge FSM with registered output payload
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            wfid_q      <= '0;
            pc_q        <= '0;
            next_pc_q   <= '0;
            literal_q   <= '0;
            lit_err_q   <= 1'b0;
            lit_count_q <= '0;
        end else if (flush_hit) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            instr_q     <= bus.in_instr;
            wfid_q      <= bus.in_wfid;
            pc_q        <= bus.in_pc;
            next_pc_q   <= next_pc_d;
            literal_q   <= '0;
            lit_err_q   <= 1'b0;
            state_q     <= bus.in_lit_req ? ST_WAIT_LIT : ST_HOLD;
            out_valid_q <= !bus.in_lit_req;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_WAIT_LIT: begin
                    if (lit_take) begin
                        literal_q[LIT_VALID_BIT]     <= 1'b1;
                        literal_q[LIT_VALID_BIT-1:0] <= bus.lit_data;
                        lit_err_q   <= (bus.lit_wfid != wfid_q);
                        lit_count_q <= lit_count_q + 16'd1;
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_d;
    assign bus.lit_ready   = lit_ready_d;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = instr_q;
    assign bus.out_wfid    = wfid_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_next_pc = next_pc_q;
    assign bus.out_literal = literal_q;
    assign bus.out_lit_err = lit_err_q;
    assign lit_count       = lit_count_q;

endmodule

// File: tb/tb_decode_literal_merge.sv
// Self-checking bench for decode_literal_merge: scoreboard of merged instructions
// plus per-scenario inline checks of handshakes, flush, backpressure and reset.
module tb_decode_literal_merge;

    localparam int WFID_W = 6;
    localparam int PC_W   = 32;

    typedef struct {
        logic [63:0]       instr;
        logic              is64;
        logic [WFID_W-1:0] wfid;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   next_pc;
        logic [32:0]       literal;
        logic              lit_err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [WFID_W-1:0] flush_wfid = '0;
    logic [15:0]       lit_count;

    int   checks = 0;
    int   errors = 0;
    int   exp_lit_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    decode_literal_merge_if #(.WFID_W(WFID_W), .PC_W(PC_W)) bus();

    decode_literal_merge #(.WFID_W(WFID_W), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_wfid (flush_wfid),
        .bus        (bus),
        .lit_count  (lit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Scoreboard monitor: every completed issue handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready && !(flush && flush_wfid == bus.out_wfid)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got output pc=%h with no expectation pending", bus.out_pc);
            end else begin
                logic [63:0] mask;
                mon_e = sb.pop_front();
                mask  = mon_e.is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
                if ((bus.out_instr & mask) !== (mon_e.instr & mask) || bus.out_wfid !== mon_e.wfid ||
                    bus.out_pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL sb_ident: got instr=%h wfid=%0d pc=%h want instr=%h wfid=%0d pc=%h",
                             bus.out_instr, bus.out_wfid, bus.out_pc, mon_e.instr, mon_e.wfid, mon_e.pc);
                end
                checks++;
                if (bus.out_next_pc !== mon_e.next_pc) begin
                    errors++;
                    $display("FAIL sb_next_pc: got %h want %h", bus.out_next_pc, mon_e.next_pc);
                end
                checks++;
                if (bus.out_literal !== mon_e.literal || bus.out_lit_err !== mon_e.lit_err) begin
                    errors++;
                    $display("FAIL sb_literal: got lit=%h err=%b want lit=%h err=%b",
                             bus.out_literal, bus.out_lit_err, mon_e.literal, mon_e.lit_err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] instr, input logic is64, input logic [WFID_W-1:0] wfid,
                         input logic [PC_W-1:0] pc, input logic lit_req);
        bus.in_valid   = 1'b1;
        bus.in_instr   = instr;
        bus.in_is64    = is64;
        bus.in_wfid    = wfid;
        bus.in_pc      = pc;
        bus.in_lit_req = lit_req;
    endtask

    task automatic push_exp(input logic [63:0] instr, input logic is64, input logic [WFID_W-1:0] wfid,
                            input logic [PC_W-1:0] pc, input logic [32:0] literal, input logic lit_err);
        exp_t e;
        e.instr   = instr;
        e.is64    = is64;
        e.wfid    = wfid;
        e.pc      = pc;
        e.next_pc = pc + (is64 ? 32'd8 : 32'd4) + (literal[32] ? 32'd4 : 32'd0);
        e.literal = literal;
        e.lit_err = lit_err;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_instr = '0; bus.in_is64 = 0; bus.in_wfid = '0; bus.in_pc = '0;
        bus.in_lit_req = 0; bus.lit_valid = 0; bus.lit_data = '0; bus.lit_wfid = '0; bus.out_ready = 0;
        rst = 1;
        repeat (3) step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.lit_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got out_valid=%b lit_ready=%b in_ready=%b want 0 0 0",
                     bus.out_valid, bus.lit_ready, bus.in_ready);
        end
        checks++;
        if (bus.out_literal !== 33'h0 || bus.out_lit_err !== 1'b0 || lit_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_literal: got lit=%h err=%b count=%0d want 0 0 0",
                     bus.out_literal, bus.out_lit_err, lit_count);
        end
        checks++;
        if (bus.out_pc !== '0 || bus.out_next_pc !== '0 || bus.out_instr !== '0 || bus.out_wfid !== '0) begin
            errors++;
            $display("FAIL reset_payload: got pc=%h npc=%h instr=%h wfid=%0d want all 0",
                     bus.out_pc, bus.out_next_pc, bus.out_instr, bus.out_wfid);
        end
        rst = 0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_plain();
        bus.out_ready = 1;
        drive(64'hAAAA_BBBB_1234_5678, 1'b0, 6'd1, 32'h100, 1'b0);
        push_exp(64'hAAAA_BBBB_1234_5678, 1'b0, 6'd1, 32'h100, 33'h0, 1'b0);
        step();
        bus.in_valid = 0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_next_pc !== 32'h104 || bus.out_literal !== 33'h0) begin
            errors++;
            $display("FAIL plain_out: got valid=%b npc=%h lit=%h want 1 00000104 0",
                     bus.out_valid, bus.out_next_pc, bus.out_literal);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL plain_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_literal();
        bus.out_ready = 1;
        drive(64'h0102_0304_0506_0708, 1'b1, 6'd2, 32'h200, 1'b1);
        push_exp(64'h0102_0304_0506_0708, 1'b1, 6'd2, 32'h200, {1'b1, 32'hDEADBEEF}, 1'b0);
        step();
        bus.in_valid = 0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.lit_ready !== 1'b1) begin
            errors++;
            $display("FAIL lit_wait: got out_valid=%b lit_ready=%b want 0 1", bus.out_valid, bus.lit_ready);
        end
        step();
        bus.lit_valid = 1; bus.lit_data = 32'hDEADBEEF; bus.lit_wfid = 6'd2;
        step();
        bus.lit_valid = 0;
        exp_lit_count++;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_next_pc !== 32'h20C || lit_count !== 16'(exp_lit_count)) begin
            errors++;
            $display("FAIL lit_merge: got valid=%b npc=%h count=%0d want 1 0000020c %0d",
                     bus.out_valid, bus.out_next_pc, lit_count, exp_lit_count);
        end
        step();
    endtask

    task automatic test_same_cycle_lit();
        bus.out_ready = 1;
        drive(64'h0000_0000_7777_7777, 1'b0, 6'd7, 32'h300, 1'b1);
        bus.lit_valid = 1; bus.lit_data = 32'h1234_5678; bus.lit_wfid = 6'd7;
        push_exp(64'h0000_0000_7777_7777, 1'b0, 6'd7, 32'h300, {1'b1, 32'h1234_5678}, 1'b0);
        #1;
        checks++;
        if (bus.lit_ready !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_lit_ready: got %b want 0", bus.lit_ready);
        end
        step();
        bus.in_valid = 0;
        checks++;
        if (bus.lit_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_next: got lit_ready=%b out_valid=%b want 1 0", bus.lit_ready, bus.out_valid);
        end
        step();
        bus.lit_valid = 0;
        exp_lit_count++;
        checks++;
        if (bus.out_valid !== 1'b1 || lit_count !== 16'(exp_lit_count)) begin
            errors++;
            $display("FAIL same_cycle_merge: got valid=%b count=%0d want 1 %0d", bus.out_valid, lit_count, exp_lit_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        drive(64'h4444_4444_4444_4444, 1'b0, 6'd1, 32'h400, 1'b0);
        push_exp(64'h4444_4444_4444_4444, 1'b0, 6'd1, 32'h400, 33'h0, 1'b0);
        step();
        drive(64'h5555_5555_5555_5555, 1'b1, 6'd2, 32'h500, 1'b0);
        push_exp(64'h5555_5555_5555_5555, 1'b1, 6'd2, 32'h500, 33'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_pc !== 32'h400 ||
                bus.out_instr[31:0] !== 32'h4444_4444 || bus.out_next_pc !== 32'h404) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b in_ready=%b pc=%h npc=%h want 1 0 00000400 00000404",
                         i, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_next_pc);
            end
            step();
        end
        bus.out_ready = 1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h500) begin
            errors++;
            $display("FAIL bp_next: got valid=%b pc=%h want 1 00000500", bus.out_valid, bus.out_pc);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            logic [63:0]       instr;
            logic              is64;
            logic [WFID_W-1:0] wfid;
            logic [PC_W-1:0]   pc;
            instr = {$urandom, $urandom};
            is64  = 1'($urandom_range(0, 1));
            wfid  = WFID_W'($urandom_range(0, 63));
            pc    = $urandom;
            drive(instr, is64, wfid, pc, 1'b0);
            push_exp(instr, is64, wfid, pc, 33'h0, 1'b0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            step();
        end
        bus.in_valid = 0;
        step();
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1;
        drive(64'h6666_6666_6666_6666, 1'b0, 6'd5, 32'h600, 1'b1);
        step();
        bus.in_valid = 0;
        flush = 1; flush_wfid = 6'd5;
        bus.lit_valid = 1; bus.lit_data = 32'hAAAA_5555; bus.lit_wfid = 6'd5;
        #1;
        checks++;
        if (bus.lit_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_match_ready: got lit_ready=%b in_ready=%b want 0 0", bus.lit_ready, bus.in_ready);
        end
        step();
        flush = 0; bus.lit_valid = 0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || lit_count !== 16'(exp_lit_count) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_match_state: got valid=%b count=%0d in_ready=%b want 0 %0d 1",
                     bus.out_valid, lit_count, bus.in_ready, exp_lit_count);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_match_quiet[%0d]: got out_valid=%b want 0", i, bus.out_valid);
            end
        end
        drive(64'h7777_0000_7777_0000, 1'b0, 6'd5, 32'h700, 1'b1);
        push_exp(64'h7777_0000_7777_0000, 1'b0, 6'd5, 32'h700, {1'b1, 32'hBBBB_6666}, 1'b0);
        step();
        bus.in_valid = 0;
        flush = 1; flush_wfid = 6'd6;
        bus.lit_valid = 1; bus.lit_data = 32'hBBBB_6666; bus.lit_wfid = 6'd5;
        #1;
        checks++;
        if (bus.lit_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_other_ready: got lit_ready=%b in_ready=%b want 1 0", bus.lit_ready, bus.in_ready);
        end
        step();
        flush = 0; bus.lit_valid = 0;
        exp_lit_count++;
        checks++;
        if (bus.out_valid !== 1'b1 || lit_count !== 16'(exp_lit_count)) begin
            errors++;
            $display("FAIL flush_other_merge: got valid=%b count=%0d want 1 %0d", bus.out_valid, lit_count, exp_lit_count);
        end
        step();
    endtask

    task automatic test_lit_mismatch();
        bus.out_ready = 1;
        drive(64'h8888_8888_8888_8888, 1'b1, 6'd3, 32'h800, 1'b1);
        push_exp(64'h8888_8888_8888_8888, 1'b1, 6'd3, 32'h800, {1'b1, 32'hCAFE_F00D}, 1'b1);
        step();
        bus.in_valid = 0;
        bus.lit_valid = 1; bus.lit_data = 32'hCAFE_F00D; bus.lit_wfid = 6'd4;
        step();
        bus.lit_valid = 0;
        exp_lit_count++;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_lit_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_err: got valid=%b err=%b want 1 1", bus.out_valid, bus.out_lit_err);
        end
        step();
    endtask

    task automatic test_pc_wrap();
        bus.out_ready = 1;
        drive(64'h9999_9999_9999_9999, 1'b1, 6'd10, 32'hFFFF_FFFC, 1'b1);
        push_exp(64'h9999_9999_9999_9999, 1'b1, 6'd10, 32'hFFFF_FFFC, {1'b1, 32'h0BAD_CAFE}, 1'b0);
        step();
        bus.in_valid = 0;
        bus.lit_valid = 1; bus.lit_data = 32'h0BAD_CAFE; bus.lit_wfid = 6'd10;
        step();
        bus.lit_valid = 0;
        exp_lit_count++;
        checks++;
        if (bus.out_next_pc !== 32'h8) begin
            errors++;
            $display("FAIL pc_wrap: got %h want 00000008", bus.out_next_pc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0;
        drive(64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 6'd9, 32'h900, 1'b0);
        push_exp(64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 6'd9, 32'h900, 33'h0, 1'b0);
        step();
        bus.in_valid = 0;
        checks++;
        if (bus.out_valid !== 1'b1 || lit_count === 16'h0) begin
            errors++;
            $display("FAIL rst_mid_pre: got valid=%b count=%0d want 1 nonzero", bus.out_valid, lit_count);
        end
        rst = 1; flush = 1; flush_wfid = 6'd9;
        step();
        void'(sb.pop_back());
        exp_lit_count = 0;
        checks++;
        if (bus.out_valid !== 1'b0 || lit_count !== 16'h0 || bus.in_ready !== 1'b0 || bus.lit_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got valid=%b count=%0d in_ready=%b lit_ready=%b want 0 0 0 0",
                     bus.out_valid, lit_count, bus.in_ready, bus.lit_ready);
        end
        rst = 0; flush = 0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_idle: got in_ready=%b want 1", bus.in_ready);
        end
        bus.out_ready = 1;
        drive(64'h0B0B_0B0B_0B0B_0B0B, 1'b1, 6'd11, 32'hA00, 1'b0);
        push_exp(64'h0B0B_0B0B_0B0B_0B0B, 1'b1, 6'd11, 32'hA00, 33'h0, 1'b0);
        step();
        bus.in_valid = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_plain();
        test_literal();
        test_same_cycle_lit();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_lit_mismatch();
        test_pc_wrap();
        test_reset_mid();
        repeat (2) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expectations want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_literal_merge.md
# decode_literal_merge

Decode-side stage that pairs each decoded instruction with its trailing 32-bit literal constant. It sits directly downstream of the per-operand register-field encoders, whose `literal_required` outputs are OR-ed into `in_lit_req`. When that flag is set, it pulls the next dword from the fetch literal stream. It then presents one merged instruction to issue, holding it in a single-entry output register and computing the next PC.

## Interface
Parameters:
- `WFID_W`, 6, wavefront ID width
- `PC_W`, 32, PC width

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset
- `flush`  in  1  squash everything in flight for `flush_wfid`
- `flush_wfid`  in  WFID_W  wavefront being flushed
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_instr`  in  64  raw instruction bits, upper 32 are don't-care when `in_is64`=0
- `in_is64`  in  1  64-bit encoding
- `in_wfid`  in  WFID_W  owning wavefront
- `in_pc`  in  PC_W  instruction PC
- `in_lit_req`  in  1  OR of the encoders' `literal_required`
- `lit_valid`  in  1  literal dword present
- `lit_ready`  out  1  literal consumed this cycle
- `lit_data`  in  32  literal dword
- `lit_wfid`  in  WFID_W  wavefront of literal dword
- `out_valid`  out  1  merged instruction valid
- `out_ready`  in  1  issue accepts
- `out_instr`  out  64  registered instruction
- `out_wfid`  out  WFID_W  registered wavefront
- `out_pc`  out  PC_W  registered PC
- `out_next_pc`  out  PC_W  PC + 4 or 8, plus 4 if a literal was merged
- `out_literal`  out  33  bit 32 = literal valid, [31:0] = literal; same format as the encoder `fp_constant`
- `out_lit_err`  out  1  literal wfid mismatched instruction wfid
- `lit_count`  out  16  merged-literal count, wraps

## Operation
FSM states:
- IDLE: no instruction held; `in_ready` = 1 when `flush`=0.
- WAIT_LIT: instruction captured, waiting for its literal.
- HOLD: merged result valid on the outputs.

Accept in IDLE (`in_valid & in_ready`):
- Capture instr/wfid/pc/is64.
- If `in_lit_req`=0: go to HOLD with `out_literal` = {1'b0, 32'h0}.
- If `in_lit_req`=1: go to WAIT_LIT.

WAIT_LIT:
- `lit_ready` = 1.
- On `lit_valid`: capture `lit_data` into `out_literal` = {1'b1, lit_data}, set `out_lit_err` = (`lit_wfid` != captured wfid), increment `lit_count`, go to HOLD.
- `lit_ready` = 0 in every other state.

HOLD:
- `out_valid` = 1.
- On `out_ready`: return to IDLE. The same cycle may accept a new instruction, so `in_ready` = `out_ready` & ~`flush` in HOLD (zero-bubble back-to-back).

Next-PC arithmetic is modulo 2^PC_W: `out_next_pc` = `out_pc` + (is64 ? 8 : 4) + (literal ? 4 : 0). Computed at capture, registered.

Flush:
- If `flush` and captured wfid == `flush_wfid` in WAIT_LIT or HOLD: go to IDLE, drop `out_valid`, do not count the literal.
- `flush` deasserts `in_ready` regardless of wfid.
- Flush with a non-matching wfid leaves state untouched.

Reset: state IDLE, `out_valid`=0, `lit_ready`=0, `out_literal`=0, `out_lit_err`=0, `lit_count`=0, `out_instr`/`out_pc`/`out_next_pc`/`out_wfid`=0. `in_ready` is 0 during reset.

## Timing
- Latency with no literal: instruction accepted at edge N, `out_valid` high after edge N.
- Latency with a literal: the literal is consumed at edge M ≥ N+1, `out_valid` high after edge M.
- A literal arriving in the same cycle as its instruction is not consumed; it is taken the following cycle at the earliest.
- Output fields are stable while `out_valid`=1 and `out_ready`=0.
- Flush has priority over every handshake in the same cycle: a matching flush during `lit_valid` does not consume the literal (`lit_ready` = 0 that cycle).
- Reset has priority over flush.
- `lit_count` wraps 16'hFFFF to 0.

## Structure
- Shared decode package holds:
  - FSM state encoding (IDLE=2'd0, WAIT_LIT=2'd1, HOLD=2'd2)
  - `LIT_VALID_BIT` = 32
  - PC increment constants (4, 8)
- Single module, no sub-module; `next_pc` adder inline.

## Test plan
- **Plain 32-bit:** `in_pc`=32'h100, is64=0, lit_req=0 → `out_valid` next cycle, `out_next_pc`=32'h104, `out_literal`=33'h0.
- **64-bit with literal:** pc=32'h200, is64=1, lit_req=1; `lit_data`=32'hDEADBEEF two cycles later → `out_literal`={1,32'hDEADBEEF}, `out_next_pc`=32'h20C, `lit_count`=1.
- **Backpressure then back-to-back:** hold `out_ready`=0 for 3 cycles → outputs stable and `in_ready`=0; then `out_ready`=1 with a new `in_valid` → new instruction accepted the same cycle, valid again the next cycle.
- **Flush in WAIT_LIT:** wfid=5, lit_req=1; `flush`=1 with `flush_wfid`=5 and `lit_valid`=1 the same cycle → IDLE, `lit_ready`=0, `lit_count` unchanged, `out_valid` never asserted. Repeat with `flush_wfid`=6 → literal merged normally.
- **Literal mismatch:** instruction wfid 3, literal wfid 4 → `out_lit_err`=1, literal still merged.
- **Reset mid-operation:** assert `rst` in HOLD → next cycle `out_valid`=0, `lit_count`=0, state IDLE. PC wrap: pc=32'hFFFFFFFC, is64=1 with literal → `out_next_pc`=32'h8.
